prewish_debounce_multi: RTL and testbench

//  Parametrised successor to the single-button debouncer. Debounces NUM_CH raw pad inputs,

---
 rtl/prewish_debounce_pkg.sv | 18 +
 rtl/debounce_ch.sv | 45 ++++
 rtl/prewish_debounce_multi.sv | 125 ++++++++++++
 tb/tb_prewish_debounce_multi.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prewish_debounce_pkg.sv
// Shared command and handshake-state encodings for the multi-channel debouncer.
// Pure definitions: no latency, no backpressure.
package prewish_debounce_pkg;

  localparam logic [1:0] CMD_STATUS = 2'b00;
  localparam logic [1:0] CMD_PRESS  = 2'b01;
  localparam logic [1:0] CMD_REL    = 2'b10;
  localparam logic [1:0] CMD_RSVD   = 2'b11;

  // Encoding is fixed: existing callers decode these values.
  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT_REL = 2'b01,
    S_ACK      = 2'b11,
    S_BAD      = 2'b10
  } state_t;

endpackage

// File: rtl/debounce_ch.sv
// One pad channel: 2FF synchroniser, lockout timer, debounced level and change pulses.
// Pad change reaches deb 3 clocks later; no backpressure, rise/fall are single-cycle pulses.
module debounce_ch #(
  parameter int TIME_PERIOD = 100000,
  parameter int TIME_BITS   = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad,
  output logic deb,
  output logic rise,
  output logic fall
);

  localparam logic [TIME_BITS-1:0] RELOAD = TIME_BITS'(TIME_PERIOD - 1);

  logic                 sync1;
  logic                 sync2;
  logic [TIME_BITS-1:0] timer;
  logic                 take;

  // rise/fall coincide with the clock edge that updates deb
  assign take = (timer == '0) && (sync2 != deb);
  assign rise = take & sync2;
  assign fall = take & ~sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      timer <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      if (take) begin
        deb   <= sync2;
        timer <= RELOAD;
      end else if (timer != '0) begin
        timer <= timer - TIME_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/prewish_debounce_multi.sv
// NUM_CH debounced buttons with sticky press/release flags, served over the STB_I/STB_O strobe handshake.
// Capture on first STB_I=1 edge, STB_O one clock after STB_I drops; caller paces requests by strobe.
module prewish_debounce_multi
  import prewish_debounce_pkg::*;
#(
  parameter int         NUM_CH      = 8,
  parameter int         TIME_PERIOD = 100000,
  parameter int         TIME_BITS   = 17,
  parameter logic [7:0] INVERT_MASK = 8'h00
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              STB_I,
  input  logic [7:0]        DAT_I,
  output logic              STB_O,
  output logic [7:0]        DAT_O,
  input  logic [NUM_CH-1:0] i_buttons,
  output logic              o_alive
);

  logic [NUM_CH-1:0] deb_vec;
  logic [NUM_CH-1:0] rise_vec;
  logic [NUM_CH-1:0] fall_vec;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] rel;
  logic [NUM_CH-1:0] clr_press;
  logic [NUM_CH-1:0] clr_rel;
  logic [7:0]        snap;
  logic [7:0]        dat_reg;
  logic              capture;
  logic              alive;
  state_t            state;
  logic              unused_dat;

  assign unused_dat = ^DAT_I[7:2];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    debounce_ch #(
      .TIME_PERIOD(TIME_PERIOD),
      .TIME_BITS  (TIME_BITS)
    ) u_ch (
      .clk  (CLK_I),
      .rst_n(RST_I),
      .pad  (i_buttons[n] ^ INVERT_MASK[n]),
      .deb  (deb_vec[n]),
      .rise (rise_vec[n]),
      .fall (fall_vec[n])
    );
  end

  assign capture = (state == S_IDLE) && STB_I;

  // Snapshot and the flags it clears are taken from the same pre-edge values.
  always_comb begin
    snap      = 8'h00;
    clr_press = '0;
    clr_rel   = '0;
    case (DAT_I[1:0])
      CMD_STATUS: snap = 8'(deb_vec);
      CMD_PRESS: begin
        snap = 8'(press);
        if (capture) clr_press = press;
      end
      CMD_REL: begin
        snap = 8'(rel);
        if (capture) clr_rel = rel;
      end
      CMD_RSVD: snap = 8'h00;
      default:  snap = 8'h00;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      press <= '0;
      rel   <= '0;
      alive <= 1'b0;
    end else begin
      press <= (press & ~clr_press) | rise_vec;
      rel   <= (rel & ~clr_rel) | fall_vec;
      if (|rise_vec) alive <= ~alive;
    end
  end

  assign o_alive = ~alive;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state   <= S_IDLE;
      STB_O   <= 1'b0;
      dat_reg <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          STB_O <= 1'b0;
          if (STB_I) begin
            dat_reg <= snap;
            state   <= S_WAIT_REL;
          end
        end
        S_WAIT_REL: begin
          if (!STB_I) begin
            STB_O <= 1'b1;
            state <= S_ACK;
          end
        end
        S_ACK: begin
          STB_O <= 1'b0;
          state <= S_IDLE;
        end
        S_BAD: begin
          STB_O <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          STB_O <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign DAT_O = dat_reg;

endmodule

// File: tb/tb_prewish_debounce_multi.sv
// Self-checking bench for prewish_debounce_multi in its small-timer build (4 channels, ch3 active-low).
module tb_prewish_debounce_multi;

  localparam int         TP   = 37;
  localparam logic [3:0] MASK = 4'h8;

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b0;
  logic       STB_I = 1'b0;
  logic [7:0] DAT_I = 8'h00;
  logic [3:0] i_buttons = 4'b1000;
  logic       STB_O;
  logic [7:0] DAT_O;
  logic       o_alive;

  int checks = 0;
  int errors = 0;

  prewish_debounce_multi #(
    .NUM_CH     (4),
    .TIME_PERIOD(TP),
    .TIME_BITS  (6),
    .INVERT_MASK(8'h08)
  ) dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .STB_I    (STB_I),
    .DAT_I    (DAT_I),
    .STB_O    (STB_O),
    .DAT_O    (DAT_O),
    .i_buttons(i_buttons),
    .o_alive  (o_alive)
  );

  always #5 CLK_I = ~CLK_I;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: cycle-numbered lockout, pad history delay line, flag sets.
  int         m_cyc = 0;
  int         m_last [4];
  logic [3:0] m_hist1 = '0, m_hist2 = '0;
  logic [3:0] m_deb = '0, m_press = '0, m_rel = '0;
  logic       m_alive = 1'b0;
  logic [7:0] m_snap = 8'h00;
  int         req_cnt = 0;
  int         served_cnt = 0;

  always @(posedge CLK_I or negedge RST_I) begin
    logic [3:0] rise, fall, clr_p, clr_r;
    if (!RST_I) begin
      m_deb = '0; m_press = '0; m_rel = '0; m_alive = 1'b0;
      m_hist1 = '0; m_hist2 = '0; m_snap = 8'h00;
      served_cnt = req_cnt;
      for (int i = 0; i < 4; i++) m_last[i] = m_cyc - TP;
    end else begin
      m_cyc++;
      clr_p = '0; clr_r = '0; rise = '0; fall = '0;
      if (req_cnt != served_cnt) begin
        served_cnt = req_cnt;
        case (DAT_I[1:0])
          2'b00: m_snap = {4'h0, m_deb};
          2'b01: begin m_snap = {4'h0, m_press}; clr_p = m_press; end
          2'b10: begin m_snap = {4'h0, m_rel}; clr_r = m_rel; end
          default: m_snap = 8'h00;
        endcase
      end
      for (int i = 0; i < 4; i++) begin
        if (m_hist2[i] != m_deb[i] && (m_cyc - m_last[i]) >= TP) begin
          if (m_hist2[i]) rise[i] = 1'b1; else fall[i] = 1'b1;
          m_deb[i]  = m_hist2[i];
          m_last[i] = m_cyc;
        end
      end
      m_hist2 = m_hist1;
      m_hist1 = i_buttons ^ MASK;
      m_press = (m_press & ~clr_p) | rise;
      m_rel   = (m_rel & ~clr_r) | fall;
      if (|rise) m_alive = ~m_alive;
    end
  end

  // Called at a negedge; returns at a negedge with the FSM back in IDLE.
  task automatic do_read(input logic [7:0] cmd, input int hold, output logic [7:0] got);
    int n;
    DAT_I = cmd;
    STB_I = 1'b1;
    req_cnt++;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK_I);
      checks++;
      if (STB_O !== 1'b0) begin
        errors++;
        $display("FAIL stb_early: STB_O=%b while STB_I high, required 0", STB_O);
      end
    end
    STB_I = 1'b0;
    n = 0;
    do begin
      @(negedge CLK_I);
      n++;
    end while (STB_O !== 1'b1 && n < 8);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL stb_latency: STB_O seen after %0d clk, required 1", n);
    end
    got = DAT_O;
    checks++;
    if (DAT_O !== m_snap) begin
      errors++;
      $display("FAIL read_model cmd=%h: DAT_O=%h, required %h", cmd, DAT_O, m_snap);
    end
    @(negedge CLK_I);
    checks++;
    if (STB_O !== 1'b0) begin
      errors++;
      $display("FAIL stb_width: STB_O=%b one clk after pulse, required 0", STB_O);
    end
  endtask

  task automatic test_reset;
    logic [7:0] got;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK_I);
      i_buttons = 4'($urandom);
      checks++;
      if (STB_O !== 1'b0 || DAT_O !== 8'h00 || o_alive !== 1'b1) begin
        errors++;
        $display("FAIL reset_outputs: STB_O=%b DAT_O=%h o_alive=%b, required 0 00 1", STB_O, DAT_O, o_alive);
      end
    end
    i_buttons = 4'b1000;
    @(negedge CLK_I);
    RST_I = 1'b1;
    repeat (5) @(negedge CLK_I);
    do_read(8'h00, 1, got);
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL reset_status: got %h, required 00", got);
    end
  endtask

  task automatic test_bounce;
    logic [7:0] got;
    i_buttons[0] = 1'b1;
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          repeat (5) @(negedge CLK_I);
          i_buttons[0] = (k % 2 == 0);
        end
      end
      begin
        repeat (2) @(negedge CLK_I);
        checks++;
        if (o_alive !== 1'b1) begin
          errors++;
          $display("FAIL deb_early: o_alive=%b two clk after press, required 1", o_alive);
        end
        @(negedge CLK_I);
        checks++;
        if (o_alive !== 1'b0) begin
          errors++;
          $display("FAIL deb_t0_3: o_alive=%b three clk after press, required 0", o_alive);
        end
        repeat (14) @(negedge CLK_I);
        do_read(8'h00, 1, got);
        checks++;
        if (got !== 8'h01) begin
          errors++;
          $display("FAIL status_in_bounce: got %h, required 01", got);
        end
      end
    join
    repeat (40) @(negedge CLK_I);
    do_read(8'h00, 1, got);
    checks++;
    if (got !== 8'h01 || o_alive !== 1'b0) begin
      errors++;
      $display("FAIL status_after_bounce: got %h alive=%b, required 01 0", got, o_alive);
    end
    do_read(8'h01, 1, got);
    checks++;
    if (got !== 8'h01) begin
      errors++;
      $display("FAIL press_ch0: got %h, required 01", got);
    end
  endtask

  task automatic test_simul_press;
    logic [7:0] got;
    i_buttons[1] = 1'b1;
    i_buttons[2] = 1'b1;
    repeat (5) @(negedge CLK_I);
    do_read(8'h01, 1, got);
    checks++;
    if (got !== 8'h06) begin
      errors++;
      $display("FAIL press_simul: got %h, required 06", got);
    end
    do_read(8'h01, 1, got);
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL press_cleared: got %h, required 00", got);
    end
  endtask

  task automatic test_release;
    logic [7:0] got;
    repeat (40) @(negedge CLK_I);
    i_buttons[1] = 1'b0;
    repeat (5) @(negedge CLK_I);
    do_read(8'h02, 1, got);
    checks++;
    if (got !== 8'h02) begin
      errors++;
      $display("FAIL rel_ch1: got %h, required 02", got);
    end
    // ch2 fall is accepted on the very edge that captures the next read
    i_buttons[2] = 1'b0;
    repeat (2) @(negedge CLK_I);
    do_read(8'h02, 1, got);
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL rel_race_capture: got %h, required 00", got);
    end
    do_read(8'h02, 1, got);
    checks++;
    if (got !== 8'h04) begin
      errors++;
      $display("FAIL rel_race_kept: got %h, required 04", got);
    end
  endtask

  task automatic test_invert_hold;
    logic [7:0] got;
    i_buttons[0] = 1'b0;
    i_buttons[3] = 1'b0;
    repeat (6) @(negedge CLK_I);
    do_read(8'h00, 1, got);
    checks++;
    if (got !== 8'h08) begin
      errors++;
      $display("FAIL status_active_low: got %h, required 08", got);
    end
    do_read(8'h03, 1, got);
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL cmd_reserved: got %h, required 00", got);
    end
    do_read(8'h00, 10, got);
    checks++;
    if (got !== 8'h08) begin
      errors++;
      $display("FAIL long_strobe: got %h, required 08", got);
    end
  endtask

  task automatic test_random;
    logic [7:0] got;
    int gap;
    for (int it = 0; it < 40; it++) begin
      gap = $urandom_range(30, 0);
      for (int c = 0; c < gap; c++) begin
        @(negedge CLK_I);
        checks++;
        if (o_alive !== ~m_alive) begin
          errors++;
          $display("FAIL rand_alive: o_alive=%b, required %b", o_alive, ~m_alive);
        end
        if ($urandom_range(7, 0) == 0) i_buttons[$urandom_range(3, 0)] ^= 1'b1;
      end
      do_read(8'($urandom), $urandom_range(4, 1), got);
    end
  endtask

  task automatic test_reset_midtxn;
    logic [7:0] got;
    repeat (40) @(negedge CLK_I);
    i_buttons = 4'b0000;
    repeat (40) @(negedge CLK_I);
    DAT_I = 8'h00;
    STB_I = 1'b1;
    req_cnt++;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    STB_I = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_I);
      checks++;
      if (STB_O !== 1'b0 || DAT_O !== 8'h00 || o_alive !== 1'b1) begin
        errors++;
        $display("FAIL midtxn_reset: STB_O=%b DAT_O=%h o_alive=%b, required 0 00 1", STB_O, DAT_O, o_alive);
      end
    end
    RST_I = 1'b1;
    repeat (6) @(negedge CLK_I);
    do_read(8'h00, 1, got);
    checks++;
    if (got !== 8'h08) begin
      errors++;
      $display("FAIL after_reset_status: got %h, required 08", got);
    end
    do_read(8'h02, 1, got);
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL after_reset_rel: got %h, required 00", got);
    end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_simul_press;
    test_release;
    test_invert_hold;
    test_random;
    test_reset_midtxn;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
